// File: rtl/fir_mac_sequencer.sv
// 19-tap symmetric low-pass FIR, one tap per cycle through an external shared multiplier.
// state | meaning: IDLE wait for sample | MAC accumulate taps | ROUND round+saturate | OUT hold result
module fir_mac_sequencer #(
  parameter int DW    = 16,
  parameter int NTAPS = 19
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [DW-1:0]   Data,
  input  logic            DataIn_valid,
  output logic            DataIn_ready,
  output logic [DW-1:0]   DataOut,
  output logic            Data_valid,
  input  logic            DataOut_ready,
  output logic [DW-1:0]   mult_a,
  output logic [DW-1:0]   mult_b,
  input  logic [2*DW-1:0] mult_p,
  output logic            busy
);

  localparam int ACCW = 36;
  localparam int TAPW = 5;
  localparam int RW   = ACCW - 16;
  localparam logic [TAPW-1:0] LAST_TAP = TAPW'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TAPW-1:0] tap_q, tap_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [DW-1:0]   dline_q [NTAPS];
  logic [DW-1:0]   dline_d [NTAPS];

  logic [ACCW-1:0] acc_rnd;
  logic [RW-1:0]   r_val;

  function automatic logic [DW-1:0] coef(input logic [TAPW-1:0] idx);
    logic [DW-1:0] c;
    case (idx)
      5'd0:    c = DW'(26);
      5'd1:    c = DW'(270);
      5'd2:    c = DW'(963);
      5'd3:    c = DW'(2424);
      5'd4:    c = DW'(4869);
      5'd5:    c = DW'(8259);
      5'd6:    c = DW'(12194);
      5'd7:    c = DW'(15948);
      5'd8:    c = DW'(18666);
      5'd9:    c = DW'(19660);
      5'd10:   c = DW'(18666);
      5'd11:   c = DW'(15948);
      5'd12:   c = DW'(12194);
      5'd13:   c = DW'(8259);
      5'd14:   c = DW'(4869);
      5'd15:   c = DW'(2424);
      5'd16:   c = DW'(963);
      5'd17:   c = DW'(270);
      5'd18:   c = DW'(26);
      default: c = '0;
    endcase
    return c;
  endfunction

  // Round half-up at bit 16; anything left above the output width saturates.
  assign acc_rnd = acc_q + ACCW'(32768);
  assign r_val   = acc_rnd[ACCW-1:16];

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    for (int k = 0; k < NTAPS; k++) dline_d[k] = dline_q[k];
    mult_a  = '0;
    mult_b  = '0;

    case (state_q)
      S_IDLE: begin
        if (DataIn_valid) begin
          for (int k = 1; k < NTAPS; k++) dline_d[k] = dline_q[k-1];
          dline_d[0] = Data;
          acc_d      = '0;
          tap_d      = '0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        mult_a = coef(tap_q);
        mult_b = dline_q[tap_q];
        acc_d  = acc_q + ACCW'(mult_p);
        tap_d  = tap_q + TAPW'(1);
        if (tap_q == LAST_TAP) state_d = S_ROUND;
      end
      S_ROUND: begin
        dout_d  = (|r_val[RW-1:DW]) ? '1 : r_val[DW-1:0];
        state_d = S_OUT;
      end
      S_OUT: begin
        if (DataOut_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      for (int k = 0; k < NTAPS; k++) dline_q[k] <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      for (int k = 0; k < NTAPS; k++) dline_q[k] <= dline_d[k];
    end
  end

  assign DataIn_ready = (state_q == S_IDLE);
  assign Data_valid   = (state_q == S_OUT);
  assign busy         = (state_q != S_IDLE);
  assign DataOut      = dout_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed + randomized bench for fir_mac_sequencer against a sum-of-products reference model.
module tb_fir_mac_sequencer;

  localparam int DW = 16;
  localparam int NT = 19;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [DW-1:0]   Data = '0;
  logic            DataIn_valid = 1'b0;
  logic            DataIn_ready;
  logic [DW-1:0]   DataOut;
  logic            Data_valid;
  logic            DataOut_ready = 1'b0;
  logic [DW-1:0]   mult_a, mult_b;
  logic [2*DW-1:0] mult_p;
  logic            busy;

  int tests = 0;
  int fails = 0;
  int unsigned hist [NT];
  int unsigned coefs [NT] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660,
                              18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26};
  logic [DW-1:0] last_out;

  assign mult_p = mult_a * mult_b;

  fir_mac_sequencer #(.DW(DW), .NTAPS(NT)) dut (
    .CLK(CLK), .RST_N(RST_N), .Data(Data), .DataIn_valid(DataIn_valid),
    .DataIn_ready(DataIn_ready), .DataOut(DataOut), .Data_valid(Data_valid),
    .DataOut_ready(DataOut_ready), .mult_a(mult_a), .mult_b(mult_b),
    .mult_p(mult_p), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned model_out();
    longint unsigned s = 0;
    longint unsigned r;
    for (int k = 0; k < NT; k++) s += longint'(coefs[k]) * longint'(hist[k]);
    r = (s + 32768) >> 16;
    if (r > 65535) r = 65535;
    return r;
  endfunction

  task automatic clear_hist();
    for (int k = 0; k < NT; k++) hist[k] = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    DataIn_valid = 1'b0;
    DataOut_ready = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ready", DataIn_ready, 1);
    check("rst_valid", Data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", DataOut, 0);
    RST_N = 1'b1;
    clear_hist();
  endtask

  // Accept one sample, verify latency/result, stall `stall` cycles with DataIn_valid high, then handshake.
  task automatic send(input logic [DW-1:0] v, input int stall);
    int cyc;
    logic [DW-1:0] held;
    @(negedge CLK);
    check("pre_ready", DataIn_ready, 1);
    Data = v;
    DataIn_valid = 1'b1;
    @(posedge CLK);
    #1;
    DataIn_valid = 1'b0;
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    check("mac_busy", busy, 1);
    check("mac_notready", DataIn_ready, 0);
    cyc = 1;
    while (!Data_valid && cyc < 40) begin
      @(posedge CLK);
      #1;
      if (!Data_valid) cyc++;
    end
    check("latency", cyc, 20);
    check("dout", DataOut, model_out());
    check("out_mult_a", mult_a, 0);
    held = DataOut;
    for (int i = 0; i < stall; i++) begin
      Data = DW'($urandom);
      DataIn_valid = 1'b1;
      @(posedge CLK);
      #1;
      check("stall_valid", Data_valid, 1);
      check("stall_dout", DataOut, held);
      check("stall_notready", DataIn_ready, 0);
    end
    DataOut_ready = 1'b1;
    @(posedge CLK);
    #1;
    DataOut_ready = 1'b0;
    check("hs_valid_drop", Data_valid, 0);
    check("hs_idle_ready", DataIn_ready, 1);
    check("hs_not_busy", busy, 0);
    DataIn_valid = 1'b0;
    last_out = held;
  endtask

  initial begin
    clear_hist();
    last_out = '0;
    do_reset();

    // single full-scale sample
    send(16'hFFFF, 0);
    check("single_26", last_out, 26);

    // impulse response
    do_reset();
    send(16'hFFFF, 0);
    for (int i = 1; i < 10; i++) send(16'd0, 0);
    check("impulse_center", last_out, 19660);

    // DC 1000
    do_reset();
    for (int i = 0; i < NT; i++) send(16'd1000, 0);
    check("dc1000", last_out, 2241);

    // DC full-scale saturates
    do_reset();
    for (int i = 0; i < NT; i++) send(16'hFFFF, 0);
    check("dc_sat", last_out, 65535);

    // output stall with input pressure, then one more accept
    send(16'd1234, 5);
    send(16'd4321, 0);

    // reset mid-MAC at tap 7
    @(negedge CLK);
    Data = 16'hFFFF;
    DataIn_valid = 1'b1;
    @(posedge CLK);
    #1;
    DataIn_valid = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", Data_valid, 0);
    check("abort_ready", DataIn_ready, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    clear_hist();
    begin
      int seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(negedge CLK);
        if (Data_valid) seen++;
      end
      check("abort_no_pulse", seen, 0);
    end
    send(16'hFFFF, 0);
    check("abort_zero_hist", last_out, 26);

    // randomized samples and stalls
    for (int i = 0; i < 30; i++) send(DW'($urandom), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning sample, coefficient and output width (unsigned).
REQ-002 SHALL have parameter NTAPS, default 19, meaning tap count (fixed at 19 for this release).
REQ-003 SHALL have port CLK, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port Data, input, DW bits: new input sample.
REQ-006 SHALL have port DataIn_valid, input, 1 bit: Data is valid.
REQ-007 SHALL have port DataIn_ready, output, 1 bit: block accepts a sample this cycle.
REQ-008 SHALL have port DataOut, output, DW bits: rounded, saturated filter result.
REQ-009 SHALL have port Data_valid, output, 1 bit: DataOut is valid.
REQ-010 SHALL have port DataOut_ready, input, 1 bit: downstream consumes DataOut.
REQ-011 SHALL have port mult_a, output, DW bits: coefficient operand to the shared combinational multiplier.
REQ-012 SHALL have port mult_b, output, DW bits: sample operand to the shared multiplier.
REQ-013 SHALL have port mult_p, input, 2*DW bits: product mult_a*mult_b, same cycle.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL hold constant coefficients c[0..18] = 26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660, 18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26.
REQ-016 SHALL keep a 19-entry delay line d[0..18], where d[0] is the newest sample.
REQ-017 SHALL implement FSM states IDLE, MAC, ROUND and OUT.
REQ-018 SHALL drive DataIn_ready = 1 only in IDLE.
REQ-019 SHALL, on an IDLE edge with DataIn_valid=1, shift d[k+1]<=d[k], load d[0]<=Data, clear acc, set tap=0, and enter MAC.
REQ-020 SHALL, in MAC, drive mult_a=c[tap], mult_b=d[tap], and update acc<=acc+mult_p and tap<=tap+1 each edge.
REQ-021 SHALL exit MAC to ROUND on the edge that accumulates tap 18, making exactly 19 MAC cycles.
REQ-022 SHALL size acc at 36 bits unsigned with no wrap possible.
REQ-023 SHALL, in ROUND, register r=(acc+2^15)>>16 and set DataOut=65535 if r>65535 (saturate), else r[15:0]; then enter OUT.
REQ-024 SHALL hold Data_valid=1 in OUT, with DataOut stable until the edge where DataOut_ready=1, then enter IDLE.
REQ-025 SHALL assert Data_valid on the 20th rising edge after the accept edge and keep it high while DataOut_ready remains low.
REQ-026 SHALL ignore DataIn_valid outside IDLE: no shift and no sample loss accounting.
REQ-027 SHALL NOT accept a new sample in the same cycle as the output handshake; IDLE is re-entered first.
REQ-028 SHALL drive mult_a=0 and mult_b=0 outside MAC.
REQ-029 SHALL produce an output for every accepted sample, including before 19 samples are loaded (missing history reads as zero).

Reset
REQ-030 SHALL, while RST_N=0, immediately force state=IDLE, d[*]=0, acc=0, tap=0, DataOut=0, Data_valid=0, busy=0, DataIn_ready=1 after release.
REQ-031 SHALL, on reset asserted mid-MAC or mid-OUT, abort the operation, discard the partial result and produce no Data_valid pulse.

Verification
REQ-032 SHALL cover: reset, then one sample 65535 -> DataOut=26, Data_valid 20 cycles after accept.
REQ-033 SHALL cover: impulse 65535 followed by 9 zeros -> outputs track c[k]*65535 rounded; 10th output=19660.
REQ-034 SHALL cover: 19 samples of 1000 -> 19th output=2241.
REQ-035 SHALL cover: 19 samples of 65535 -> 19th output saturates to 65535.
REQ-036 SHALL cover: DataOut_ready held low 5 cycles in OUT with DataIn_valid=1 -> DataOut stable, DataIn_ready=0, no shift; one sample accepted after return to IDLE.
REQ-037 SHALL cover: RST_N pulsed low at MAC tap 7 -> Data_valid stays 0, busy=0, and the next single sample 65535 gives 26 (zeroed history).
